// File: rtl/xo_decode_pkg.sv
// Shared types and opcode constants for the XO-form decode stage.
package xo_decode_pkg;

    localparam int unsigned XO_REG_W = 5;
    localparam int unsigned XO_XOP_W = 9;
    localparam int unsigned OPC_XO   = 31;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_DIV = 2'd2
    } unit_t;

    localparam logic [XO_XOP_W-1:0] XOP_ADD    = 9'd266;
    localparam logic [XO_XOP_W-1:0] XOP_SUBF   = 9'd40;
    localparam logic [XO_XOP_W-1:0] XOP_ADDC   = 9'd10;
    localparam logic [XO_XOP_W-1:0] XOP_SUBFC  = 9'd8;
    localparam logic [XO_XOP_W-1:0] XOP_ADDE   = 9'd138;
    localparam logic [XO_XOP_W-1:0] XOP_SUBFE  = 9'd136;
    localparam logic [XO_XOP_W-1:0] XOP_ADDME  = 9'd234;
    localparam logic [XO_XOP_W-1:0] XOP_SUBFME = 9'd232;
    localparam logic [XO_XOP_W-1:0] XOP_SUBFZE = 9'd200;
    localparam logic [XO_XOP_W-1:0] XOP_ADDZE  = 9'd202;
    localparam logic [XO_XOP_W-1:0] XOP_NEG    = 9'd104;
    localparam logic [XO_XOP_W-1:0] XOP_ADDG6S = 9'd74;

    localparam logic [XO_XOP_W-1:0] XOP_MULLW  = 9'd235;
    localparam logic [XO_XOP_W-1:0] XOP_MULHW  = 9'd75;
    localparam logic [XO_XOP_W-1:0] XOP_MULHWU = 9'd11;
    localparam logic [XO_XOP_W-1:0] XOP_MULLD  = 9'd233;
    localparam logic [XO_XOP_W-1:0] XOP_MULHD  = 9'd73;
    localparam logic [XO_XOP_W-1:0] XOP_MULHDU = 9'd9;

    localparam logic [XO_XOP_W-1:0] XOP_DIVW   = 9'd491;
    localparam logic [XO_XOP_W-1:0] XOP_DIVWU  = 9'd459;
    localparam logic [XO_XOP_W-1:0] XOP_DIVWE  = 9'd427;
    localparam logic [XO_XOP_W-1:0] XOP_DIVWEU = 9'd395;
    localparam logic [XO_XOP_W-1:0] XOP_DIVD   = 9'd489;
    localparam logic [XO_XOP_W-1:0] XOP_DIVDU  = 9'd457;
    localparam logic [XO_XOP_W-1:0] XOP_DIVDE  = 9'd425;
    localparam logic [XO_XOP_W-1:0] XOP_DIVDEU = 9'd393;

    typedef struct packed {
        logic [XO_REG_W-1:0] rt;
        logic [XO_REG_W-1:0] ra;
        logic [XO_REG_W-1:0] rb;
        logic [XO_XOP_W-1:0] xop;
        logic                oe;
        logic                rc;
        unit_t               unit;
        logic                illegal;
    } xo_entry_t;

endpackage

// File: rtl/xo_decode_stage_if.sv
// Instruction-in / decoded-entry-out handshake bundle for xo_decode_stage.
interface xo_decode_stage_if #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned REG_WIDTH   = 5,
    parameter int unsigned XOP_WIDTH   = 9
);
    logic                   valid_i;
    logic [INSTR_WIDTH-1:0] instruction_i;
    logic                   ready_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [REG_WIDTH-1:0]   rt_o;
    logic [REG_WIDTH-1:0]   ra_o;
    logic [REG_WIDTH-1:0]   rb_o;
    logic [XOP_WIDTH-1:0]   xop_o;
    logic                   oe_o;
    logic                   rc_o;
    logic [1:0]             unit_o;
    logic                   illegal_o;

    modport slave (
        input  valid_i, instruction_i, ready_i,
        output ready_o, valid_o, rt_o, ra_o, rb_o, xop_o, oe_o, rc_o, unit_o, illegal_o
    );

    modport master (
        output valid_i, instruction_i, ready_i,
        input  ready_o, valid_o, rt_o, ra_o, rb_o, xop_o, oe_o, rc_o, unit_o, illegal_o
    );
endinterface

// File: rtl/xo_xop_classify.sv
// Maps an opcode-31 extended opcode to its execution unit and legality.
module xo_xop_classify
    import xo_decode_pkg::*;
#(
    parameter bit SUPPORT_64 = 1'b1
) (
    input  logic [XO_XOP_W-1:0] xop_i,
    output unit_t               unit_o,
    output logic                legal_o
);
    logic dword;

    always_comb begin
        unit_o  = UNIT_ALU;
        legal_o = 1'b0;
        dword   = 1'b0;
        case (xop_i)
            XOP_ADD, XOP_SUBF, XOP_ADDC, XOP_SUBFC, XOP_ADDE, XOP_SUBFE,
            XOP_ADDME, XOP_SUBFME, XOP_SUBFZE, XOP_ADDZE, XOP_NEG, XOP_ADDG6S: begin
                legal_o = 1'b1;
            end
            XOP_MULLW, XOP_MULHW, XOP_MULHWU: begin
                unit_o  = UNIT_MUL;
                legal_o = 1'b1;
            end
            XOP_MULLD, XOP_MULHD, XOP_MULHDU: begin
                unit_o  = UNIT_MUL;
                legal_o = 1'b1;
                dword   = 1'b1;
            end
            XOP_DIVW, XOP_DIVWU, XOP_DIVWE, XOP_DIVWEU: begin
                unit_o  = UNIT_DIV;
                legal_o = 1'b1;
            end
            XOP_DIVD, XOP_DIVDU, XOP_DIVDE, XOP_DIVDEU: begin
                unit_o  = UNIT_DIV;
                legal_o = 1'b1;
                dword   = 1'b1;
            end
            default: ;
        endcase
        // Illegal ops are always reported against the ALU.
        if (dword && !SUPPORT_64) begin
            unit_o  = UNIT_ALU;
            legal_o = 1'b0;
        end
    end
endmodule

// File: rtl/xo_decode_stage.sv
// XO-form decode stage: opcode-31 field extraction and unit classification,
// followed by a 2-entry skid buffer so downstream backpressure never drops work.
module xo_decode_stage
    import xo_decode_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned XOP_WIDTH    = 9,
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter bit          SUPPORT_64   = 1'b1,
    parameter bit          EMIT_ILLEGAL = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    xo_decode_stage_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Power numbering: bit 0 is the MSB of the instruction word.
    localparam int unsigned MSB    = INSTR_WIDTH - 1;
    localparam int unsigned RT_MSB = MSB - OPCODE_WIDTH;
    localparam int unsigned RA_MSB = RT_MSB - REG_WIDTH;
    localparam int unsigned RB_MSB = RA_MSB - REG_WIDTH;
    localparam int unsigned OE_BIT = RB_MSB - REG_WIDTH;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [XOP_WIDTH-1:0]    xop;
    unit_t                   cls_unit;
    logic                    cls_legal;
    logic                    is_xo;
    logic                    enq;
    logic                    pop;
    xo_entry_t               new_entry;

    logic      head_v_q, head_v_d;
    logic      skid_v_q, skid_v_d;
    logic      ready_q, ready_d;
    xo_entry_t head_q, head_d;
    xo_entry_t skid_q, skid_d;

    assign opcode = bus.instruction_i[MSB -: OPCODE_WIDTH];
    assign xop    = bus.instruction_i[XOP_WIDTH:1];
    assign is_xo  = (opcode == OPCODE_WIDTH'(OPC_XO));

    xo_xop_classify #(
        .SUPPORT_64(SUPPORT_64)
    ) u_classify (
        .xop_i  (xop),
        .unit_o (cls_unit),
        .legal_o(cls_legal)
    );

    always_comb begin
        new_entry.rt      = bus.instruction_i[RT_MSB -: REG_WIDTH];
        new_entry.ra      = bus.instruction_i[RA_MSB -: REG_WIDTH];
        new_entry.rb      = bus.instruction_i[RB_MSB -: REG_WIDTH];
        new_entry.xop     = xop;
        new_entry.oe      = bus.instruction_i[OE_BIT];
        new_entry.rc      = bus.instruction_i[0];
        new_entry.unit    = cls_unit;
        new_entry.illegal = !cls_legal;
    end

    assign enq = bus.valid_i & ready_q & is_xo & (cls_legal | EMIT_ILLEGAL);
    assign pop = head_v_q & bus.ready_i;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        case ({head_v_q, skid_v_q})
            ST_EMPTY: begin
                if (enq) begin
                    head_d   = new_entry;
                    head_v_d = 1'b1;
                end
            end
            ST_ONE: begin
                if (enq && pop) begin
                    head_d = new_entry;
                end else if (enq) begin
                    skid_d   = new_entry;
                    skid_v_d = 1'b1;
                end else if (pop) begin
                    head_v_d = 1'b0;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d   = skid_q;
                    skid_v_d = 1'b0;
                end
            end
            default: begin
                head_v_d = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase
        if (flush_i) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        ready_d = !skid_v_d;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clock_i) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    assign bus.ready_o   = ready_q;
    assign bus.valid_o   = head_v_q;
    assign bus.rt_o      = head_q.rt;
    assign bus.ra_o      = head_q.ra;
    assign bus.rb_o      = head_q.rb;
    assign bus.xop_o     = head_q.xop;
    assign bus.oe_o      = head_q.oe;
    assign bus.rc_o      = head_q.rc;
    assign bus.unit_o    = head_q.unit;
    assign bus.illegal_o = head_q.illegal;
endmodule

// File: tb/tb_xo_decode_stage.sv
// Bench for xo_decode_stage: three mode variants driven in parallel and
// compared against a FIFO-occupancy reference model.
module tb_xo_decode_stage;
    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [8:0] xop;
        logic       oe;
        logic       rc;
        logic [1:0] unit;
        logic       ill;
    } ent_t;

    // dut0: 64-bit + emit, dut1: 32-bit + emit, dut2: 32-bit + silent drop
    localparam logic [2:0] S64_MASK  = 3'b001;
    localparam logic [2:0] EMIT_MASK = 3'b011;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        rdy   = 1'b1;
    logic [31:0] instr = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    xo_decode_stage_if b0 ();
    xo_decode_stage_if b1 ();
    xo_decode_stage_if b2 ();

    assign b0.valid_i = valid;  assign b0.instruction_i = instr;  assign b0.ready_i = rdy;
    assign b1.valid_i = valid;  assign b1.instruction_i = instr;  assign b1.ready_i = rdy;
    assign b2.valid_i = valid;  assign b2.instruction_i = instr;  assign b2.ready_i = rdy;

    xo_decode_stage #(.SUPPORT_64(1'b1), .EMIT_ILLEGAL(1'b1)) u_dut0 (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .bus(b0));
    xo_decode_stage #(.SUPPORT_64(1'b0), .EMIT_ILLEGAL(1'b1)) u_dut1 (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .bus(b1));
    xo_decode_stage #(.SUPPORT_64(1'b0), .EMIT_ILLEGAL(1'b0)) u_dut2 (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .bus(b2));

    logic [2:0] av, ar;
    ent_t       ae [3];
    assign av = {b2.valid_o, b1.valid_o, b0.valid_o};
    assign ar = {b2.ready_o, b1.ready_o, b0.ready_o};
    assign ae[0] = {b0.rt_o, b0.ra_o, b0.rb_o, b0.xop_o, b0.oe_o, b0.rc_o, b0.unit_o, b0.illegal_o};
    assign ae[1] = {b1.rt_o, b1.ra_o, b1.rb_o, b1.xop_o, b1.oe_o, b1.rc_o, b1.unit_o, b1.illegal_o};
    assign ae[2] = {b2.rt_o, b2.ra_o, b2.rb_o, b2.xop_o, b2.oe_o, b2.rc_o, b2.unit_o, b2.illegal_o};

    // Reference: per-DUT FIFO of at most two expected entries.
    ent_t m_ent [3][2];
    int   m_cnt [3];
    bit   m_rdy [3];

    function automatic int unsigned pf(input logic [31:0] w, input int unsigned a, input int unsigned b);
        logic [31:0] s;
        s = w >> (31 - b);
        return s & ((32'd1 << (b - a + 1)) - 32'd1);
    endfunction

    function automatic bit model_decode(input logic [31:0] w, input bit s64, input bit emit, output ent_t e);
        int unsigned x;
        int          u;
        x = pf(w, 22, 30);
        if (x inside {266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 74}) u = 0;
        else if (x inside {235, 75, 11, 233, 73, 9}) u = 1;
        else if (x inside {491, 459, 427, 395, 489, 457, 425, 393}) u = 2;
        else u = -1;
        if (!s64 && (x inside {233, 73, 9, 489, 457, 425, 393})) u = -1;
        e.rt   = 5'(pf(w, 6, 10));
        e.ra   = 5'(pf(w, 11, 15));
        e.rb   = 5'(pf(w, 16, 20));
        e.xop  = 9'(x);
        e.oe   = 1'(pf(w, 21, 21));
        e.rc   = 1'(pf(w, 31, 31));
        e.unit = (u < 0) ? 2'd0 : 2'(u);
        e.ill  = (u < 0);
        return (pf(w, 0, 5) == 31) && ((u >= 0) || emit);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                ent_t e;
                bit   acc;
                acc = valid && m_rdy[k];
                if (!rst_n) begin
                    m_cnt[k] = 0;
                    m_rdy[k] = 1'b0;
                end else if (flush) begin
                    m_cnt[k] = 0;
                    m_rdy[k] = 1'b1;
                end else begin
                    if (m_cnt[k] > 0 && rdy) begin
                        m_ent[k][0] = m_ent[k][1];
                        m_cnt[k]--;
                    end
                    if (acc && model_decode(instr, S64_MASK[k], EMIT_MASK[k], e)) begin
                        m_ent[k][m_cnt[k]] = e;
                        m_cnt[k]++;
                    end
                    m_rdy[k] = (m_cnt[k] < 2);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input int unsigned rt, input int unsigned ra,
                                        input int unsigned rb, input int unsigned xop);
        return {6'd31, 5'(rt), 5'(ra), 5'(rb), 1'b0, 9'(xop), 1'b0};
    endfunction

    function automatic ent_t mk(input int unsigned rt, input int unsigned ra, input int unsigned rb,
                                input int unsigned xop, input int unsigned unit, input int unsigned ill);
        ent_t e;
        e.rt = 5'(rt);  e.ra = 5'(ra);  e.rb = 5'(rb);  e.xop = 9'(xop);
        e.oe = 1'b0;    e.rc = 1'b0;    e.unit = 2'(unit);  e.ill = 1'(ill);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        valid = 1'b0; rdy = 1'b1; flush = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        ent_t exp;
        rst_n = 1'b0; valid = 1'b0; rdy = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b0 || ar[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: valid_o=%b ready_o=%b expected 0/0", k, av[k], ar[k]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ar[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_release dut%0d: ready_o=%b expected 1", k, ar[k]);
            end
        end
        valid = 1'b1; instr = 32'h7C642A14;
        tick();
        valid = 1'b0;
        exp = mk(3, 4, 5, 266, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b1 || ae[k] !== exp) begin
                n_fail++;
                $display("FAIL first_add dut%0d: valid_o=%b entry=%h expected 1 %h", k, av[k], ae[k], exp);
            end
        end
        tick();
        n_tests++;
        if (av[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_add_popped: valid_o=%b expected 0", av[0]);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] w [4];
        ent_t        exp [3];
        int          idx [3];
        int          got;
        w[0] = enc(1, 2, 3, 235);  w[1] = enc(4, 5, 6, 491);
        w[2] = 32'h38600001;       w[3] = enc(7, 8, 9, 40);
        exp[0] = mk(1, 2, 3, 235, 1, 0);
        exp[1] = mk(4, 5, 6, 491, 2, 0);
        exp[2] = mk(7, 8, 9, 40, 0, 0);
        idx = '{1, 2, 4};
        got = 0; rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0 && av[0]) begin
                n_tests++;
                if (got >= 3) begin
                    n_fail++;
                    $display("FAIL stream_extra: cycle %0d entry=%h expected no output", i, ae[0]);
                end else if (ae[0] !== exp[got] || i != idx[got]) begin
                    n_fail++;
                    $display("FAIL stream_entry%0d: cycle %0d entry=%h expected cycle %0d %h",
                             got, i, ae[0], idx[got], exp[got]);
                end
                got++;
            end
            if (i < 4) begin valid = 1'b1; instr = w[i]; end
            else valid = 1'b0;
            tick();
        end
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs expected 3", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        ent_t        exp [3];
        ent_t        seen [$];
        bit          acc;
        w[0] = enc(13, 1, 2, 266);  w[1] = enc(14, 3, 4, 235);  w[2] = enc(15, 5, 6, 491);
        exp[0] = mk(13, 1, 2, 266, 0, 0);
        exp[1] = mk(14, 3, 4, 235, 1, 0);
        exp[2] = mk(15, 5, 6, 491, 2, 0);
        rdy = 1'b0; valid = 1'b1; instr = w[0];
        tick();
        instr = w[1];
        n_tests++;
        if (ar[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_one_held: ready_o=%b expected 1", ar[0]);
        end
        tick();
        instr = w[2];
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (ar[0] !== 1'b0 || av[0] !== 1'b1 || ae[0] !== exp[0]) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: ready_o=%b valid_o=%b entry=%h expected 0 1 %h",
                         c, ar[0], av[0], ae[0], exp[0]);
            end
            tick();
        end
        rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (av[0]) seen.push_back(ae[0]);
            acc = valid && ar[0];
            tick();
            if (acc) valid = 1'b0;
        end
        n_tests++;
        if (seen.size() != 3) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d entries expected 3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (seen[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL bp_drain_order%0d: entry=%h expected %h", i, seen[i], exp[i]);
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_modes();
        logic [31:0] w [3];
        ent_t        exp_ent [3][3];
        int          exp_n [3];
        ent_t        got_ent [3][4];
        int          got_n [3];
        w[0] = enc(10, 1, 1, 489);  w[1] = enc(11, 1, 1, 500);  w[2] = enc(12, 1, 1, 266);
        exp_ent[0][0] = mk(10, 1, 1, 489, 2, 0);
        exp_ent[0][1] = mk(11, 1, 1, 500, 0, 1);
        exp_ent[0][2] = mk(12, 1, 1, 266, 0, 0);
        exp_ent[1][0] = mk(10, 1, 1, 489, 0, 1);
        exp_ent[1][1] = mk(11, 1, 1, 500, 0, 1);
        exp_ent[1][2] = mk(12, 1, 1, 266, 0, 0);
        exp_ent[2][0] = mk(12, 1, 1, 266, 0, 0);
        exp_ent[2][1] = '0;
        exp_ent[2][2] = '0;
        exp_n = '{3, 3, 1};
        got_n = '{0, 0, 0};
        rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (i > 0 && av[k] && got_n[k] < 4) begin
                    got_ent[k][got_n[k]] = ae[k];
                    got_n[k]++;
                end
            end
            if (i < 3) begin valid = 1'b1; instr = w[i]; end
            else valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (got_n[k] != exp_n[k]) begin
                n_fail++;
                $display("FAIL mode_count dut%0d: got %0d outputs expected %0d", k, got_n[k], exp_n[k]);
            end else begin
                for (int i = 0; i < exp_n[k]; i++) begin
                    n_tests++;
                    if (got_ent[k][i] !== exp_ent[k][i]) begin
                        n_fail++;
                        $display("FAIL mode_entry dut%0d #%0d: entry=%h expected %h",
                                 k, i, got_ent[k][i], exp_ent[k][i]);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        rdy = 1'b0; valid = 1'b1; instr = enc(20, 1, 2, 266);
        tick();
        instr = enc(21, 3, 4, 40);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ar[k] !== 1'b0 || av[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_full dut%0d: ready_o=%b valid_o=%b expected 0 1", k, ar[k], av[k]);
            end
        end
        flush = 1'b1; rdy = 1'b1; valid = 1'b1; instr = enc(22, 5, 6, 235);
        tick();
        flush = 1'b0; valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_clears dut%0d: valid_o=%b expected 0", k, av[k]);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b0 || ar[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_after dut%0d: valid_o=%b ready_o=%b expected 0 1", k, av[k], ar[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t exp;
        rdy = 1'b0; valid = 1'b1; instr = enc(24, 1, 2, 266);
        tick();
        instr = enc(25, 3, 4, 40);
        tick();
        rst_n = 1'b0; rdy = 1'b1; instr = enc(26, 5, 6, 235);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b0 || ar[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_outputs dut%0d: valid_o=%b ready_o=%b expected 0 0", k, av[k], ar[k]);
            end
        end
        rst_n = 1'b1; valid = 1'b0;
        tick();
        valid = 1'b1; instr = enc(27, 7, 8, 491);
        tick();
        valid = 1'b0;
        exp = mk(27, 7, 8, 491, 2, 0);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (av[k] !== 1'b1 || ae[k] !== exp) begin
                n_fail++;
                $display("FAIL midreset_first dut%0d: valid_o=%b entry=%h expected 1 %h", k, av[k], ae[k], exp);
            end
        end
    endtask

    task automatic test_random(input int unsigned cycles);
        logic [8:0] pool [26] = '{266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 74,
                                  235, 75, 11, 233, 73, 9,
                                  491, 459, 427, 395, 489, 457, 425, 393};
        logic [8:0] xop;
        logic [5:0] op;
        int unsigned sel;
        for (int unsigned c = 0; c < cycles; c++) begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (av[k] !== (m_cnt[k] > 0) || ar[k] !== m_rdy[k]) begin
                    n_fail++;
                    $display("FAIL rand_ctrl dut%0d cycle %0d: valid_o=%b ready_o=%b expected %b %b",
                             k, c, av[k], ar[k], (m_cnt[k] > 0), m_rdy[k]);
                end else if (av[k] && ae[k] !== m_ent[k][0]) begin
                    n_fail++;
                    $display("FAIL rand_head dut%0d cycle %0d: entry=%h expected %h", k, c, ae[k], m_ent[k][0]);
                end
            end
            flush = ($urandom_range(0, 49) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            valid = ($urandom_range(0, 3) != 0);
            sel   = $urandom_range(0, 5);
            xop   = (sel < 4) ? pool[$urandom_range(0, 25)] : 9'($urandom);
            instr = {6'd31, 15'($urandom), 1'($urandom), xop, 1'($urandom)};
            if (sel == 5) begin
                op = 6'($urandom_range(0, 62));
                if (op >= 6'd31) op = op + 6'd1;
                instr[31:26] = op;
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        drain();
        test_streaming();
        drain();
        test_backpressure();
        drain();
        test_modes();
        drain();
        test_flush();
        drain();
        test_reset_mid();
        drain();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
